// File: rtl/spi_speed_arbiter_if.sv
// Speed-command handshake bundle between requesters and the SPI speed arbiter.
// master = command sources / fault input, slave = arbiter.
interface spi_speed_arbiter_if;
    logic        req0_valid;
    logic [15:0] req0_data;
    logic        req0_ready;
    logic        req1_valid;
    logic [15:0] req1_data;
    logic        req1_ready;
    logic        fault;
    logic [15:0] wdata;
    logic        we;
    logic        fault_active;
    logic        busy;

    modport master (
        output req0_valid, req0_data,
        output req1_valid, req1_data,
        output fault,
        input  req0_ready, req1_ready,
        input  wdata, we, fault_active, busy
    );

    modport slave (
        input  req0_valid, req0_data,
        input  req1_valid, req1_data,
        input  fault,
        output req0_ready, req1_ready,
        output wdata, we, fault_active, busy
    );
endinterface

// File: rtl/spi_speed_arbiter.sv
// Round-robin speed-register writer with write spacing and fault pre-emption.
// Guarantees each written value survives at least one PMD901 SPI frame.
module spi_speed_arbiter #(
    parameter logic [11:0] HOLDOFF_CYCLES = 12'd2200,
    parameter logic [15:0] SAFE_SPEED     = 16'h0000
) (
    input logic                clk,
    input logic                rst,
    spi_speed_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        HOLDOFF
    } state_t;

    state_t      state;
    logic [11:0] cnt;
    logic        rr_last;
    logic [15:0] wdata_q;
    logic        we_q;
    logic        rdy0_q;
    logic        rdy1_q;
    logic        fa_q;
    logic        busy_q;

    logic        pick1;
    logic        any_valid;
    logic        fault_new;

    assign any_valid = bus.req0_valid || bus.req1_valid;
    assign fault_new = bus.fault && !fa_q;

    // Winner index; on a tie the side that did not win last time goes.
    always_comb begin
        pick1 = 1'b0;
        unique case (1'b1)
            (bus.req0_valid && bus.req1_valid):  pick1 = ~rr_last;
            (bus.req0_valid && !bus.req1_valid): pick1 = 1'b0;
            (!bus.req0_valid && bus.req1_valid): pick1 = 1'b1;
            default:                             pick1 = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= 12'd0;
            rr_last <= 1'b1;
            wdata_q <= 16'h0000;
            we_q    <= 1'b0;
            rdy0_q  <= 1'b0;
            rdy1_q  <= 1'b0;
            fa_q    <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            we_q   <= 1'b0;
            rdy0_q <= 1'b0;
            rdy1_q <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (fault_new) begin
                        wdata_q <= SAFE_SPEED;
                        we_q    <= 1'b1;
                        fa_q    <= 1'b1;
                        state   <= WRITE;
                        busy_q  <= 1'b1;
                    end else if (fa_q && !bus.fault) begin
                        fa_q <= 1'b0;
                    end else if (!fa_q && any_valid) begin
                        wdata_q <= pick1 ? bus.req1_data : bus.req0_data;
                        we_q    <= 1'b1;
                        rdy0_q  <= ~pick1;
                        rdy1_q  <= pick1;
                        rr_last <= pick1;
                        state   <= WRITE;
                        busy_q  <= 1'b1;
                    end
                end
                WRITE: begin
                    // A one-cycle holdoff is fully covered by the IDLE cycle.
                    if (HOLDOFF_CYCLES <= 12'd1) begin
                        cnt    <= 12'd0;
                        state  <= IDLE;
                        busy_q <= 1'b0;
                    end else begin
                        cnt   <= HOLDOFF_CYCLES - 12'd1;
                        state <= HOLDOFF;
                    end
                end
                HOLDOFF: begin
                    if (fault_new) begin
                        wdata_q <= SAFE_SPEED;
                        we_q    <= 1'b1;
                        fa_q    <= 1'b1;
                        state   <= WRITE;
                    end else if (cnt <= 12'd1) begin
                        cnt    <= 12'd0;
                        state  <= IDLE;
                        busy_q <= 1'b0;
                    end else begin
                        cnt <= cnt - 12'd1;
                    end
                end
                default: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.wdata        = wdata_q;
    assign bus.we           = we_q;
    assign bus.req0_ready   = rdy0_q;
    assign bus.req1_ready   = rdy1_q;
    assign bus.fault_active = fa_q;
    assign bus.busy         = busy_q;

endmodule
